// File: rtl/harness_pkg.sv
// -----------------------------------------------------------------------------
// harness_pkg
// Shared definitions for the harness command sequencer:
//   - command byte codes of the simulation-harness byte protocol
//   - sequencer state enumeration (also exported on the debug port)
//   - ceil_div helper used for byte/word sizing
// -----------------------------------------------------------------------------
package harness_pkg;

  localparam logic [7:0] CMD_SAMPLE  = 8'd104;  // snapshot DUT outputs, stream them back
  localparam logic [7:0] CMD_QUIT    = 8'd105;  // enter HALT with done=1
  localparam logic [7:0] CMD_RST_ON  = 8'd106;  // assert dut_rst
  localparam logic [7:0] CMD_RST_OFF = 8'd107;  // release dut_rst
  localparam logic [7:0] CMD_STEP    = 8'd108;  // run STEP_CYCLES enabled DUT cycles
  localparam logic [7:0] CMD_LOAD    = 8'd109;  // load INPUT_BYTES payload bytes
  localparam logic [7:0] CMD_COUNT   = 8'd110;  // return cycle_count (optional feature)

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/harness_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// harness_cmd_sequencer_if
// Host-side byte streams of the sequencer.
//   cmd_data/cmd_valid/cmd_ready : command + payload bytes into the sequencer
//   rsp_data/rsp_valid/rsp_ready : response bytes out of the sequencer
// Handshake rule for both streams: a byte transfers on a rising clk edge where
// valid and ready are both 1. Once valid is raised, the sender holds valid and
// data stable until that transfer; ready may change freely.
// Modports:
//   master : host / bridge side (drives commands, consumes responses)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface harness_cmd_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;

  modport master (
    output cmd_data, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, rsp_ready,
    output cmd_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/harness_rsp_serializer.sv
// -----------------------------------------------------------------------------
// harness_rsp_serializer
// Loads a snapshot of up to MAX_WORDS 32-bit words and emits its low load_len
// bytes, least significant byte first, over a valid/ready byte stream.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (drops any pending byte)
//   load        : capture load_data; first byte is valid on the next cycle
//   load_data   : snapshot, byte 0 in bits [7:0]
//   load_len    : number of bytes to emit (>= 1)
//   rsp_data    : current byte, stable while rsp_valid & ~rsp_ready
//   rsp_valid   : byte available
//   rsp_ready   : consumer accepts on valid & ready
//   last_done   : combinational pulse on the handshake of the final byte
// -----------------------------------------------------------------------------
module harness_rsp_serializer #(
  parameter int MAX_WORDS = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load,
  input  logic [MAX_WORDS*32-1:0]                load_data,
  input  logic [$clog2(MAX_WORDS*4+1)-1:0]       load_len,
  output logic [7:0]                             rsp_data,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic                                   last_done
);

  localparam int DATA_W = MAX_WORDS * 32;
  localparam int LEN_W  = $clog2(MAX_WORDS * 4 + 1);

  logic [DATA_W-1:0] shift_q;   // bytes still to be presented, next one in [7:0]
  logic [LEN_W-1:0]  left_q;    // bytes remaining after the one on rsp_data

  logic xfer;
  assign xfer      = rsp_valid & rsp_ready;
  assign last_done = xfer & (left_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      left_q    <= '0;
      rsp_data  <= 8'h00;
      rsp_valid <= 1'b0;
    end else if (load) begin
      rsp_data  <= load_data[7:0];
      shift_q   <= load_data >> 8;
      left_q    <= load_len - LEN_W'(1);
      rsp_valid <= 1'b1;
    end else if (xfer) begin
      if (left_q == '0) begin
        rsp_valid <= 1'b0;
      end else begin
        // Next byte goes out on the cycle right after the handshake: no bubble.
        rsp_data <= shift_q[7:0];
        shift_q  <= shift_q >> 8;
        left_q   <= left_q - LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/harness_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// harness_cmd_sequencer
// Hardware counterpart of the simulation harness: decodes the host byte
// command protocol and drives a DUT's reset, input vector and clock enable,
// returning sampled DUT outputs as a byte stream.
// Optional feature macro: HARNESS_CYCLE_COUNT_EN
//   defined   : cycle_count port (enabled DUT cycles, wraps) and command 110
//               returning it as 4 bytes LSB first
//   undefined : no cycle_count port; 110 is treated as an unknown command
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   host           : command/response byte streams (slave modport)
//   dut_rst        : DUT reset, set by 106 and rst, cleared by 107
//   dut_clk_en     : DUT clock enable, high STEP_CYCLES cycles per step
//   dut_data_in    : DUT input vector, updated when a LOAD completes
//   dut_data_out   : DUT output vector, snapshotted by SAMPLE
//   done           : QUIT executed (sticky until rst)
//   error/err_code : unknown command seen and its byte (sticky until rst)
//   cycle_count    : optional, see above
//   state_dbg      : current sequencer state
// -----------------------------------------------------------------------------
module harness_cmd_sequencer
  import harness_pkg::*;
#(
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 32,
  parameter int STEP_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  harness_cmd_sequencer_if.slave host,
  output logic                   dut_rst,
  output logic                   dut_clk_en,
  output logic [INPUT_SIZE-1:0]  dut_data_in,
  input  logic [OUTPUT_SIZE-1:0] dut_data_out,
  output logic                   done,
  output logic                   error,
  output logic [7:0]             err_code,
`ifdef HARNESS_CYCLE_COUNT_EN
  output logic [31:0]            cycle_count,
`endif
  output state_t                 state_dbg
);

  localparam int INPUT_BYTES  = ceil_div(INPUT_SIZE, 8);
  localparam int OUTPUT_WORDS = ceil_div(OUTPUT_SIZE, 32);
  localparam int SHADOW_W     = 8 * INPUT_BYTES;
  localparam int SNAP_W       = 32 * OUTPUT_WORDS;
  localparam int LEN_W        = $clog2(OUTPUT_WORDS * 4 + 1);
  localparam int LOAD_W       = $clog2(INPUT_BYTES + 1);
  localparam int STEP_W       = $clog2(STEP_CYCLES + 1);

  state_t                  state_q, state_d;
  logic                    dut_rst_d, dut_clk_en_d, done_d, error_d;
  logic [7:0]              err_code_d;
  logic [INPUT_SIZE-1:0]   dut_data_in_d;
  logic [SHADOW_W-1:0]     shadow_q, shadow_d, shadow_shift;
  logic [SHADOW_W+7:0]     shift_in;
  logic [LOAD_W-1:0]       load_cnt_q, load_cnt_d;
  logic [STEP_W-1:0]       step_cnt_q, step_cnt_d;
  logic [SNAP_W-1:0]       snap;
  logic                    ser_load, ser_last;
  logic [SNAP_W-1:0]       ser_data;
  logic [LEN_W-1:0]        ser_len;
  logic [7:0]              rsp_data_w;
  logic                    rsp_valid_w;
  logic                    cmd_fire;

  assign host.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign cmd_fire       = host.cmd_valid & host.cmd_ready;
  assign state_dbg      = state_q;

  // New payload byte enters at the top; after INPUT_BYTES bytes the first
  // byte received sits in the least significant position.
  assign shift_in     = {host.cmd_data, shadow_q};
  assign shadow_shift = shift_in[SHADOW_W+7:8];

  always_comb begin
    snap                   = '0;
    snap[OUTPUT_SIZE-1:0]  = dut_data_out;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state_q;
    dut_rst_d     = dut_rst;
    dut_clk_en_d  = dut_clk_en;
    dut_data_in_d = dut_data_in;
    done_d        = done;
    error_d       = error;
    err_code_d    = err_code;
    shadow_d      = shadow_q;
    load_cnt_d    = load_cnt_q;
    step_cnt_d    = step_cnt_q;
    ser_load      = 1'b0;
    ser_data      = snap;
    ser_len       = LEN_W'(OUTPUT_WORDS * 4);

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (host.cmd_data)
            CMD_SAMPLE: begin
              state_d  = ST_SAMPLE;
              ser_load = 1'b1;
            end
            CMD_QUIT: begin
              state_d = ST_HALT;
              done_d  = 1'b1;
            end
            CMD_RST_ON:  dut_rst_d = 1'b1;
            CMD_RST_OFF: dut_rst_d = 1'b0;
            CMD_STEP: begin
              state_d      = ST_STEP;
              dut_clk_en_d = 1'b1;
              // Counts the enabled cycles still to follow the first one.
              step_cnt_d   = STEP_W'(STEP_CYCLES - 1);
            end
            CMD_LOAD: begin
              state_d    = ST_LOAD;
              load_cnt_d = '0;
            end
`ifdef HARNESS_CYCLE_COUNT_EN
            CMD_COUNT: begin
              state_d  = ST_SAMPLE;
              ser_load = 1'b1;
              ser_data = SNAP_W'(cycle_count);
              ser_len  = LEN_W'(4);
            end
`endif
            default: begin
              state_d    = ST_HALT;
              error_d    = 1'b1;
              err_code_d = host.cmd_data;
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (cmd_fire) begin
          shadow_d = shadow_shift;
          if (load_cnt_q == LOAD_W'(INPUT_BYTES - 1)) begin
            dut_data_in_d = shadow_shift[INPUT_SIZE-1:0];
            state_d       = ST_IDLE;
          end else begin
            load_cnt_d = load_cnt_q + LOAD_W'(1);
          end
        end
      end

      ST_STEP: begin
        if (step_cnt_q == '0) begin
          dut_clk_en_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          step_cnt_d = step_cnt_q - STEP_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (ser_last) state_d = ST_IDLE;
      end

      ST_HALT: begin
        // Terminal: everything holds until rst.
      end

      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dut_rst     <= 1'b1;
      dut_clk_en  <= 1'b0;
      dut_data_in <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 8'h00;
      shadow_q    <= '0;
      load_cnt_q  <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dut_rst     <= dut_rst_d;
      dut_clk_en  <= dut_clk_en_d;
      dut_data_in <= dut_data_in_d;
      done        <= done_d;
      error       <= error_d;
      err_code    <= err_code_d;
      shadow_q    <= shadow_d;
      load_cnt_q  <= load_cnt_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

`ifdef HARNESS_CYCLE_COUNT_EN
  // Counts DUT cycles that actually ran (enable high); wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) cycle_count <= '0;
    else if (dut_clk_en) cycle_count <= cycle_count + 32'd1;
  end
`endif

  harness_rsp_serializer #(
    .MAX_WORDS (OUTPUT_WORDS)
  ) u_rsp (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (ser_data),
    .load_len  (ser_len),
    .rsp_data  (rsp_data_w),
    .rsp_valid (rsp_valid_w),
    .rsp_ready (host.rsp_ready),
    .last_done (ser_last)
  );

  assign host.rsp_data  = rsp_data_w;
  assign host.rsp_valid = rsp_valid_w;

endmodule

// File: tb/tb_harness_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_harness_cmd_sequencer
// Self-checking bench for harness_cmd_sequencer (INPUT_SIZE=32,
// OUTPUT_SIZE=32, STEP_CYCLES=3). Inputs are driven and outputs sampled 1 time
// unit after each rising edge. The reference model tracks dut_rst, the applied
// input vector and the enabled-cycle total; response bytes are predicted into
// exp_q from the sampled value.
// -----------------------------------------------------------------------------
module tb_harness_cmd_sequencer;
  import harness_pkg::*;

  localparam int STEPS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dut_rst, dut_clk_en, done, error;
  logic [31:0] dut_data_in;
  logic [31:0] dut_data_out = 32'h0;
  logic [7:0]  err_code;
  state_t      state_dbg;
`ifdef HARNESS_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  harness_cmd_sequencer_if host();

  harness_cmd_sequencer #(
    .INPUT_SIZE  (32),
    .OUTPUT_SIZE (32),
    .STEP_CYCLES (STEPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host.slave),
    .dut_rst      (dut_rst),
    .dut_clk_en   (dut_clk_en),
    .dut_data_in  (dut_data_in),
    .dut_data_out (dut_data_out),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
`ifdef HARNESS_CYCLE_COUNT_EN
    .cycle_count  (cycle_count),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- reference model + scoreboard ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        m_dut_rst = 1'b1;
  logic [31:0] m_data_in = 32'h0;
  logic [31:0] m_cycles  = 32'h0;
  logic [7:0]  exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    host.cmd_valid = 1'b0;
    host.rsp_ready = 1'b0;
    tick();
    rst       = 1'b0;
    m_dut_rst = 1'b1;
    m_data_in = 32'h0;
    m_cycles  = 32'h0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    host.cmd_data  = b;
    host.cmd_valid = 1'b1;
    while (host.cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    vec_cnt++;
    if (guard >= 50) begin
      err_cnt++;
      $display("FAIL send_timeout: byte %02h cmd_ready=%b, required 1", b, host.cmd_ready);
    end else begin
      tick();
    end
    host.cmd_valid = 1'b0;
  endtask

  task automatic drain_rsp(input bit stall);
    int   cyc = 0;
    bit   stalled = 0;
    bit   rdy;
    logic [7:0] held = 8'h0;
    logic [7:0] e;
    while (exp_q.size() > 0 && cyc < 200) begin
      vec_cnt++;
      if (host.rsp_valid !== 1'b1 || host.cmd_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL rsp_stream: rsp_valid=%b cmd_ready=%b, required 1/0 with %0d bytes left",
                 host.rsp_valid, host.cmd_ready, exp_q.size());
        break;
      end
      if (stalled) begin
        vec_cnt++;
        if (host.rsp_data !== held) begin
          err_cnt++;
          $display("FAIL rsp_hold: rsp_data=%02h, required held %02h", host.rsp_data, held);
        end
      end
      rdy            = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      host.rsp_ready = rdy;
      if (rdy) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if (host.rsp_data !== e) begin
          err_cnt++;
          $display("FAIL rsp_byte: rsp_data=%02h, required %02h", host.rsp_data, e);
        end
        stalled = 0;
      end else begin
        stalled = 1;
        held    = host.rsp_data;
      end
      tick();
      cyc++;
    end
    host.rsp_ready = 1'b0;
    vec_cnt++;
    if (exp_q.size() != 0 || host.rsp_valid !== 1'b0 || host.cmd_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rsp_end: left=%0d rsp_valid=%b cmd_ready=%b, required 0/0/1",
               exp_q.size(), host.rsp_valid, host.cmd_ready);
    end
    exp_q.delete();
  endtask

  task automatic op_rst(input bit v);
    send_byte(v ? CMD_RST_ON : CMD_RST_OFF);
    m_dut_rst = v;
    vec_cnt++;
    if (dut_rst !== m_dut_rst) begin
      err_cnt++;
      $display("FAIL dut_rst_cmd: dut_rst=%b, required %b", dut_rst, m_dut_rst);
    end
  endtask

  task automatic op_load(input logic [31:0] val);
    send_byte(CMD_LOAD);
    for (int i = 0; i < 4; i++) begin
      send_byte(val[8*i +: 8]);
      if (i < 3) begin
        vec_cnt++;
        if (dut_data_in !== m_data_in || host.cmd_ready !== 1'b1) begin
          err_cnt++;
          $display("FAIL load_mid: byte %0d dut_data_in=%08h cmd_ready=%b, required %08h/1",
                   i, dut_data_in, host.cmd_ready, m_data_in);
        end
      end
    end
    m_data_in = val;
    vec_cnt++;
    if (dut_data_in !== m_data_in || state_dbg !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL load_done: dut_data_in=%08h state=%0d, required %08h/IDLE",
               dut_data_in, state_dbg, m_data_in);
    end
  endtask

  task automatic op_step();
    int n = 0;
    send_byte(CMD_STEP);
    while (dut_clk_en === 1'b1 && n < 20) begin
      vec_cnt++;
      if (host.cmd_ready !== 1'b0 || dut_rst !== m_dut_rst) begin
        err_cnt++;
        $display("FAIL step_busy: cmd_ready=%b dut_rst=%b, required 0/%b",
                 host.cmd_ready, dut_rst, m_dut_rst);
      end
      n++;
      tick();
    end
    m_cycles = m_cycles + STEPS;
    vec_cnt++;
    if (n != STEPS || host.cmd_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL step_len: enable cycles=%0d cmd_ready=%b, required %0d/1",
               n, host.cmd_ready, STEPS);
    end
`ifdef HARNESS_CYCLE_COUNT_EN
    vec_cnt++;
    if (cycle_count !== m_cycles) begin
      err_cnt++;
      $display("FAIL cycle_count: got %0d, required %0d", cycle_count, m_cycles);
    end
`endif
  endtask

  task automatic op_sample(input logic [31:0] val, input bit stall);
    dut_data_out = val;
    for (int i = 0; i < 4; i++) exp_q.push_back(val[8*i +: 8]);
    send_byte(CMD_SAMPLE);
    dut_data_out = $urandom;  // the snapshot must not follow later changes
    drain_rsp(stall);
  endtask

`ifdef HARNESS_CYCLE_COUNT_EN
  task automatic op_count(input bit stall);
    for (int i = 0; i < 4; i++) exp_q.push_back(m_cycles[8*i +: 8]);
    send_byte(CMD_COUNT);
    drain_rsp(stall);
  endtask
`endif

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vec_cnt++;
    if (dut_rst !== 1'b1 || dut_clk_en !== 1'b0 || dut_data_in !== 32'h0 ||
        host.rsp_valid !== 1'b0 || host.rsp_data !== 8'h0 || done !== 1'b0 ||
        error !== 1'b0 || err_code !== 8'h0 || state_dbg !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL reset_values: rst=%b en=%b din=%08h rv=%b rd=%02h done=%b err=%b code=%02h st=%0d",
               dut_rst, dut_clk_en, dut_data_in, host.rsp_valid, host.rsp_data, done, error,
               err_code, state_dbg);
    end
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (dut_rst !== 1'b1 || host.cmd_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release: dut_rst=%b cmd_ready=%b, required 1/1", dut_rst, host.cmd_ready);
    end
  endtask

  task automatic test_dut_rst();
    op_rst(1'b0);
    op_rst(1'b1);
    op_rst(1'b0);
  endtask

  task automatic test_load();
    op_load(32'h12345678);
    for (int k = 0; k < 4; k++) op_load($urandom);
  endtask

  task automatic test_step();
    op_step();
    op_rst(1'b1);
    op_step();
    op_rst(1'b0);
  endtask

  task automatic test_sample();
    op_sample(32'hDEADBEEF, 1'b1);
    op_sample($urandom, 1'b0);
    for (int k = 0; k < 3; k++) op_sample($urandom, 1'b1);
  endtask

  task automatic test_error();
    logic [7:0] b;
    int last_cmd;
`ifdef HARNESS_CYCLE_COUNT_EN
    last_cmd = 110;
`else
    last_cmd = 109;
`endif
    for (int k = 0; k < 4; k++) begin
      if (k == 0) b = 8'h41;
      else begin
        b = 8'($urandom_range(0, 255));
        while (int'(b) >= 104 && int'(b) <= last_cmd) b = 8'($urandom_range(0, 255));
      end
      send_byte(b);
      vec_cnt++;
      if (error !== 1'b1 || err_code !== b || host.cmd_ready !== 1'b0 || done !== 1'b0) begin
        err_cnt++;
        $display("FAIL error_cmd: err=%b code=%02h cmd_ready=%b done=%b, required 1/%02h/0/0",
                 error, err_code, host.cmd_ready, done, b);
      end
      // HALT ignores further commands.
      host.cmd_data  = CMD_RST_OFF;
      host.cmd_valid = 1'b1;
      repeat (3) tick();
      host.cmd_valid = 1'b0;
      vec_cnt++;
      if (dut_rst !== m_dut_rst || error !== 1'b1 || err_code !== b || state_dbg !== ST_HALT) begin
        err_cnt++;
        $display("FAIL halt_hold: dut_rst=%b err=%b code=%02h st=%0d, required %b/1/%02h/HALT",
                 dut_rst, error, err_code, state_dbg, m_dut_rst, b);
      end
      do_reset();
    end
`ifndef HARNESS_CYCLE_COUNT_EN
    send_byte(8'd110);
    vec_cnt++;
    if (error !== 1'b1 || err_code !== 8'd110) begin
      err_cnt++;
      $display("FAIL count_unknown: err=%b code=%02h, required 1/6e", error, err_code);
    end
    do_reset();
`endif
  endtask

  task automatic test_quit();
    send_byte(CMD_QUIT);
    tick();
    tick();
    vec_cnt++;
    if (done !== 1'b1 || error !== 1'b0 || host.cmd_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL quit: done=%b err=%b cmd_ready=%b, required 1/0/0", done, error, host.cmd_ready);
    end
    do_reset();
    vec_cnt++;
    if (done !== 1'b0 || host.cmd_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL quit_clear: done=%b cmd_ready=%b, required 0/1", done, host.cmd_ready);
    end
  endtask

  task automatic test_load_abort();
    op_load($urandom | 32'h1);
    send_byte(CMD_LOAD);
    send_byte(8'hAA);
    send_byte(8'hBB);
    vec_cnt++;
    if (dut_data_in !== m_data_in) begin
      err_cnt++;
      $display("FAIL abort_mid: dut_data_in=%08h, required %08h", dut_data_in, m_data_in);
    end
    do_reset();
    vec_cnt++;
    if (dut_data_in !== 32'h0 || dut_rst !== 1'b1 || state_dbg !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL abort_reset: dut_data_in=%08h dut_rst=%b st=%0d, required 0/1/IDLE",
               dut_data_in, dut_rst, state_dbg);
    end
    op_load($urandom);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 4))
        0: op_load($urandom);
        1: op_step();
        2: op_sample($urandom, 1'($urandom_range(0, 1)));
        3: op_rst(1'($urandom_range(0, 1)));
`ifdef HARNESS_CYCLE_COUNT_EN
        default: op_count(1'($urandom_range(0, 1)));
`else
        default: op_step();
`endif
      endcase
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    host.cmd_data  = 8'h0;
    host.cmd_valid = 1'b0;
    host.rsp_ready = 1'b0;
    test_reset();
    test_dut_rst();
    test_load();
    test_step();
    test_sample();
    test_error();
    test_quit();
    test_load_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
